// File: rtl/boa_mem_arbiter.sv
// Two-master (program bus P, data bus D) to one-slave memory arbiter.
// A lone request in IDLE is forwarded combinationally with zero added latency.
// The grant is held in BUSY_P/BUSY_D until the slave answers with s_ready.
// Tie-break rule: D always wins by default. Define BOA_ARB_ROUND_ROBIN_EN to
// alternate instead, giving the tie to the master that was not served last.
module boa_mem_arbiter #(
  parameter int unsigned alen = 32,
  parameter int unsigned dlen = 32
) (
  input  logic              clk,
  input  logic              rst,
  // Program-bus master
  input  logic              p_re,
  input  logic [dlen/8-1:0] p_we,
  input  logic [alen-1:0]   p_addr,
  input  logic [dlen-1:0]   p_wdata,
  output logic              p_ready,
  output logic [dlen-1:0]   p_rdata,
  // Data-bus master
  input  logic              d_re,
  input  logic [dlen/8-1:0] d_we,
  input  logic [alen-1:0]   d_addr,
  input  logic [dlen-1:0]   d_wdata,
  output logic              d_ready,
  output logic [dlen-1:0]   d_rdata,
  // Shared slave
  output logic              s_re,
  output logic [dlen/8-1:0] s_we,
  output logic [alen-1:0]   s_addr,
  output logic [dlen-1:0]   s_wdata,
  input  logic              s_ready,
  input  logic [dlen-1:0]   s_rdata
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyP = 2'd1,
    StBusyD = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   p_req, d_req;
  logic   gnt_p, gnt_d;

  assign p_req = p_re | (|p_we);
  assign d_req = d_re | (|d_we);

`ifdef BOA_ARB_ROUND_ROBIN_EN
  // Last master served: 0 = P, 1 = D. Resets to D so P wins the first tie.
  logic last_q, last_d;

  // Last-served register, updated whenever a transfer completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  // Record the master whose transfer completed this cycle.
  always_comb begin
    last_d = last_q;
    if ((gnt_p || gnt_d) && s_ready) begin
      last_d = gnt_d;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant selection: arbitrate only in IDLE, lock to the owner while busy.
  always_comb begin
    gnt_p = 1'b0;
    gnt_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (p_req && d_req) begin
`ifdef BOA_ARB_ROUND_ROBIN_EN
          gnt_p = last_q;
          gnt_d = ~last_q;
`else
          gnt_d = 1'b1;
`endif
        end else begin
          gnt_p = p_req;
          gnt_d = d_req;
        end
      end
      StBusyP: gnt_p = 1'b1;
      StBusyD: gnt_d = 1'b1;
      default: ;
    endcase
  end

  // Next state: enter BUSY only when the slave did not finish in the grant cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (gnt_p && !s_ready) begin
          state_d = StBusyP;
        end else if (gnt_d && !s_ready) begin
          state_d = StBusyD;
        end
      end
      StBusyP, StBusyD: begin
        if (s_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output mux: exactly one source drives the slave; everything is forced to
  // zero while rst is high so an aborted transfer cannot leak out.
  always_comb begin
    s_re    = 1'b0;
    s_we    = '0;
    s_addr  = '0;
    s_wdata = '0;
    p_ready = 1'b0;
    p_rdata = '0;
    d_ready = 1'b0;
    d_rdata = '0;
    if (!rst) begin
      if (gnt_p) begin
        s_re    = p_re;
        s_we    = p_we;
        s_addr  = p_addr;
        s_wdata = p_wdata;
        p_ready = s_ready;
        p_rdata = s_rdata;
      end else if (gnt_d) begin
        s_re    = d_re;
        s_we    = d_we;
        s_addr  = d_addr;
        s_wdata = d_wdata;
        d_ready = s_ready;
        d_rdata = s_rdata;
      end
    end
  end

endmodule

// File: tb/tb_boa_mem_arbiter.sv
// Directed bench for boa_mem_arbiter; expectations cover both tie-break builds
// (BOA_ARB_ROUND_ROBIN_EN defined or not).
module tb_boa_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_re, d_re, s_re;
  logic [3:0]  p_we, d_we, s_we;
  logic [31:0] p_addr, d_addr, s_addr;
  logic [31:0] p_wdata, d_wdata, s_wdata;
  logic        p_ready, d_ready, s_ready;
  logic [31:0] p_rdata, d_rdata, s_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  boa_mem_arbiter #(.alen(32), .dlen(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .p_re    (p_re),
    .p_we    (p_we),
    .p_addr  (p_addr),
    .p_wdata (p_wdata),
    .p_ready (p_ready),
    .p_rdata (p_rdata),
    .d_re    (d_re),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ready (d_ready),
    .d_rdata (d_rdata),
    .s_re    (s_re),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_ready (s_ready),
    .s_rdata (s_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input logic re, input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] wd);
    p_re = re; p_we = we; p_addr = a; p_wdata = wd;
  endtask

  task automatic set_d(input logic re, input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] wd);
    d_re = re; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  // Expected readies for the tie cycles, chosen by build.
  logic exp_p, exp_d;

  initial begin
    // Reset with live requests and a ready slave: every output must be zero.
    rst = 1'b1;
    set_p(1'b1, 4'h0, 32'h4000_0000, 32'h0);
    set_d(1'b0, 4'hF, 32'h20, 32'h1234);
    s_ready = 1'b1; s_rdata = 32'h55;
    #2;
    check("rst_s_re",    s_re,    1'b0);
    check("rst_s_we",    s_we,    4'h0);
    check("rst_s_addr",  s_addr,  32'h0);
    check("rst_p_ready", p_ready, 1'b0);
    check("rst_d_ready", d_ready, 1'b0);
    check("rst_p_rdata", p_rdata, 32'h0);
    tick();
    rst = 1'b0;

    // Idle with no requests.
    set_p(1'b0, 4'h0, 32'h0, 32'h0);
    set_d(1'b0, 4'h0, 32'h0, 32'h0);
    s_ready = 1'b0; s_rdata = 32'h0;
    #1;
    check("idle_s_re",    s_re,    1'b0);
    check("idle_s_addr",  s_addr,  32'h0);
    check("idle_s_wdata", s_wdata, 32'h0);
    check("idle_p_ready", p_ready, 1'b0);
    check("idle_d_ready", d_ready, 1'b0);

    // Single P read answered in the same cycle.
    tick();
    set_p(1'b1, 4'h0, 32'h4000_0000, 32'h0);
    s_ready = 1'b1; s_rdata = 32'h13;
    #1;
    check("pread_s_re",    s_re,    1'b1);
    check("pread_s_addr",  s_addr,  32'h4000_0000);
    check("pread_p_ready", p_ready, 1'b1);
    check("pread_p_rdata", p_rdata, 32'h13);
    check("pread_d_ready", d_ready, 1'b0);
    check("pread_d_rdata", d_rdata, 32'h0);

    // D write with slave ready on the 4th cycle; P arrives in cycle 2 and must wait.
    tick();
    set_p(1'b0, 4'h0, 32'h0, 32'h0);
    set_d(1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF);
    s_ready = 1'b0; s_rdata = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) set_p(1'b1, 4'h0, 32'h4000_0004, 32'h0);
      if (c == 4) s_ready = 1'b1;
      #1;
      check($sformatf("dwr_c%0d_s_we", c),    s_we,    4'hF);
      check($sformatf("dwr_c%0d_s_addr", c),  s_addr,  32'h10);
      check($sformatf("dwr_c%0d_s_wdata", c), s_wdata, 32'hDEAD_BEEF);
      check($sformatf("dwr_c%0d_s_re", c),    s_re,    1'b0);
      check($sformatf("dwr_c%0d_d_ready", c), d_ready, (c == 4));
      check($sformatf("dwr_c%0d_p_ready", c), p_ready, 1'b0);
      tick();
    end
    // D done; waiting P now gets the slave back-to-back.
    set_d(1'b0, 4'h0, 32'h0, 32'h0);
    s_ready = 1'b1; s_rdata = 32'h77;
    #1;
    check("after_d_s_addr",  s_addr,  32'h4000_0004);
    check("after_d_p_ready", p_ready, 1'b1);
    check("after_d_p_rdata", p_rdata, 32'h77);
    check("after_d_d_rdata", d_rdata, 32'h0);

    // P stalled, D requests in cycle 2; P held until s_ready, then D next cycle.
    tick();
    set_p(1'b1, 4'h3, 32'h100, 32'hAAAA_5555);
    s_ready = 1'b0;
    #1;
    check("hold_c1_s_addr", s_addr, 32'h100);
    tick();
    set_d(1'b1, 4'h0, 32'h200, 32'h0);
    #1;
    check("hold_c2_s_addr",  s_addr,  32'h100);
    check("hold_c2_s_wdata", s_wdata, 32'hAAAA_5555);
    check("hold_c2_d_ready", d_ready, 1'b0);
    tick();
    s_ready = 1'b1; s_rdata = 32'h99;
    #1;
    check("hold_c3_p_ready", p_ready, 1'b1);
    check("hold_c3_s_addr",  s_addr,  32'h100);
    check("hold_c3_d_ready", d_ready, 1'b0);
    tick();
    set_p(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("hold_c4_s_addr",  s_addr,  32'h200);
    check("hold_c4_d_ready", d_ready, 1'b1);
    check("hold_c4_d_rdata", d_rdata, 32'h99);
    check("hold_c4_p_ready", p_ready, 1'b0);

    // Continuous tie with s_ready=1; last served was D.
    tick();
    set_p(1'b1, 4'h0, 32'h300, 32'h0);
    set_d(1'b1, 4'h0, 32'h400, 32'h0);
    for (int c = 0; c < 4; c++) begin
`ifdef BOA_ARB_ROUND_ROBIN_EN
      exp_p = (c % 2 == 0);
`else
      exp_p = 1'b0;
`endif
      exp_d = ~exp_p;
      #1;
      check($sformatf("tie_c%0d_p_ready", c), p_ready, exp_p);
      check($sformatf("tie_c%0d_d_ready", c), d_ready, exp_d);
      check($sformatf("tie_c%0d_s_addr", c),  s_addr,  exp_p ? 32'h300 : 32'h400);
      tick();
    end

    // Reset during BUSY_D: outputs drop at once, state returns to IDLE.
    set_p(1'b0, 4'h0, 32'h0, 32'h0);
    set_d(1'b0, 4'h1, 32'h500, 32'h1111);
    s_ready = 1'b0;
    tick();
    #1;
    check("busyd_s_addr", s_addr, 32'h500);
    set_p(1'b1, 4'h0, 32'h300, 32'h0);
    s_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("rstmid_s_we",    s_we,    4'h0);
    check("rstmid_s_addr",  s_addr,  32'h0);
    check("rstmid_s_wdata", s_wdata, 32'h0);
    check("rstmid_d_ready", d_ready, 1'b0);
    check("rstmid_p_ready", p_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
`ifdef BOA_ARB_ROUND_ROBIN_EN
    check("postrst_tie_p_ready", p_ready, 1'b1);
    check("postrst_tie_s_addr",  s_addr,  32'h300);
`else
    check("postrst_tie_d_ready", d_ready, 1'b1);
    check("postrst_tie_s_addr",  s_addr,  32'h500);
`endif
    tick();
    // A lone P request must win, proving the FSM left BUSY_D.
    set_d(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("postrst_p_ready", p_ready, 1'b1);
    check("postrst_s_addr",  s_addr,  32'h300);
    check("postrst_d_ready", d_ready, 1'b0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/boa_mem_arbiter.md
BOA_MEM_ARBITER -- requirements
Module: boa_mem_arbiter

Interface
REQ-001 SHALL have parameter alen, default 32, address width in bits.
REQ-002 SHALL have parameter dlen, default 32, data width in bits; multiple of 8.
REQ-003 SHALL have port clk  input  1  CPU clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports p_re/p_we/p_addr/p_wdata  input  1/dlen/8/alen/dlen  program-bus master request (read enable, byte write enables, address, write data).
REQ-006 SHALL have ports p_ready/p_rdata  output  1/dlen  program-bus completion and read data.
REQ-007 SHALL have ports d_re/d_we/d_addr/d_wdata  input  1/dlen/8/alen/dlen  data-bus master request.
REQ-008 SHALL have ports d_ready/d_rdata  output  1/dlen  data-bus completion and read data.
REQ-009 SHALL have ports s_re/s_we/s_addr/s_wdata  output  1/dlen/8/alen/dlen  shared memory slave request.
REQ-010 SHALL have ports s_ready/s_rdata  input  1/dlen  slave completion and read data.

Function
REQ-011 Request from master X: X_re or any X_we bit set; master holds request fields stable until X_ready.
REQ-012 States: IDLE, BUSY_P, BUSY_D; plus 1-bit register last (last master served: 0=P, 1=D).
REQ-013 IDLE, no requests: s_re=0, s_we=0, s_addr=0, s_wdata=0, p_ready=d_ready=0.
REQ-014 IDLE, one request: that master forwarded to slave combinationally in the same cycle (zero added latency).
REQ-015 IDLE, both request: winner chosen per REQ-026/REQ-027; loser sees ready=0.
REQ-016 Granted master's ready = s_ready and rdata = s_rdata; non-granted master's ready=0, rdata=0.
REQ-017 IDLE grant with s_ready=1 same cycle: transfer completes, state stays IDLE, last updated to winner.
REQ-018 IDLE grant with s_ready=0: next state BUSY_P or BUSY_D per winner.
REQ-019 BUSY_X: forward master X only, regardless of other requests; leave only when s_ready=1, then -> IDLE, last=X.
REQ-020 BUSY_X with X request withdrawn (protocol violation): forward X fields anyway; no hang check required.
REQ-021 Back-to-back: a master completing and re-requesting next cycle re-arbitrates in IDLE; no idle bubble forced.
REQ-022 Never forward both masters or change grant mid-transfer; s_* driven from exactly one source.
REQ-023 Slave-side latency unbounded; arbiter adds no cycles beyond those of REQ-014..REQ-019.

Reset
REQ-024 rst asserted (any time, incl. mid-transfer): state=IDLE, last=1 (P wins first tie), asynchronously.
REQ-025 During reset all outputs SHALL be 0; the aborted transfer is dropped, not replayed.

Configuration
REQ-026 With macro BOA_ARB_ROUND_ROBIN_EN defined: on tie, winner = master not equal to last.
REQ-027 Without BOA_ARB_ROUND_ROBIN_EN: on tie, D always wins; last register may be omitted.

Verification
REQ-028 Single P read addr 0x4000_0000, s_ready=1 same cycle, s_rdata=0x00000013 -> p_ready=1, p_rdata=0x13 same cycle, d_ready=0.
REQ-029 D write addr 0x10, we=0xF, wdata=0xDEADBEEF, s_ready after 3 cycles -> s_* stable 4 cycles, d_ready=1 on cycle 4 only, state BUSY_D in between.
REQ-030 P and D both request continuously, s_ready=1 each cycle -> with macro grants alternate P,D,P,D; without macro D served every cycle, P starved.
REQ-031 P granted with s_ready=0, D requests in cycle 2 -> P held until s_ready, then D granted next cycle.
REQ-032 rst pulsed during BUSY_D -> all outputs 0 immediately, state IDLE; after release, tie resolves to P (macro defined).
